sw_txn_arbiter: RTL

SW_TXN_ARBITER -- requirements
Module: sw_txn_arbiter

---
 rtl/sw_txn_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sw_txn_arbiter.sv
// sw_txn_arbiter: round-robin arbiter that pops one frame at a time from NUM_SW_INST request FIFOs
// and issues it to the matching switch, holding it until that switch acknowledges.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   empty_in              per-FIFO empty flags (1 = no frame)
//   frame_in              flattened FIFO heads, FIFO i at [i*FRAME_WIDTH +: FRAME_WIDTH]
//   ack_in                per-switch completion acknowledge
//   fifo_rd_en            one-hot pop strobe
//   sel_en                one-hot switch select, held while waiting for ack
//   wr_rd_s, addr,
//   wr_data, op_id        decoded fields of the issued frame
//   busy                  high whenever the FSM is not IDLE
//   timeout_err           one-cycle abort pulse
// Macro ARB_TIMEOUT_EN: when defined, WAIT_ACK aborts after TIMEOUT_CYCLES selected cycles without ack.
module sw_txn_arbiter #(
    parameter int NUM_SW_INST    = 5,
    parameter int W_WIDTH        = 8,
    parameter int FRAME_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_SW_INST-1:0]             empty_in,
    input  logic [NUM_SW_INST*FRAME_WIDTH-1:0] frame_in,
    input  logic [NUM_SW_INST-1:0]             ack_in,
    output logic [NUM_SW_INST-1:0]             fifo_rd_en,
    output logic [NUM_SW_INST-1:0]             sel_en,
    output logic                               wr_rd_s,
    output logic [W_WIDTH-1:0]                 addr,
    output logic [W_WIDTH-1:0]                 wr_data,
    output logic [7:0]                         op_id,
    output logic                               busy,
    output logic                               timeout_err
);
    localparam int IW = NUM_SW_INST > 1 ? $clog2(NUM_SW_INST) : 1;

    typedef enum logic [1:0] {IDLE, POP, LOAD, WAIT_ACK} state_t;

    state_t                 state, state_nxt;
    logic [IW-1:0]          grant, grant_nxt, last_grant, last_nxt, rr_idx;
    logic                   rr_hit, ack_hit, expire, done, load;
    logic [NUM_SW_INST-1:0] grant_oh, rd_en_nxt, sel_nxt;
    logic [FRAME_WIDTH-1:0] frame_sel;
    logic                   unused_frame;

    assign grant_oh     = NUM_SW_INST'(1) << grant;
    assign frame_sel    = frame_in[int'(grant)*FRAME_WIDTH +: FRAME_WIDTH];
    assign unused_frame = ^frame_sel;
    // Only an ack from the switch currently selected can complete the transaction.
    assign ack_hit      = |(ack_in & sel_en);
    assign done         = ack_hit | expire;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    // Ack on the expiry cycle wins, so expire is masked by ack_hit.
    assign expire = (sel_en != '0) && !ack_hit && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else
            tcnt <= (sel_en != '0 && !done) ? tcnt + 1'b1 : '0;
    end
`else
    assign expire = 1'b0;
`endif

    // Round-robin search from last_grant+1 with wrap; descending loop so the nearest index wins.
    always_comb begin
        rr_idx = '0;
        rr_hit = 1'b0;
        for (int i = NUM_SW_INST; i >= 1; i--) begin
            if (!empty_in[(int'(last_grant) + i) % NUM_SW_INST]) begin
                rr_idx = IW'((int'(last_grant) + i) % NUM_SW_INST);
                rr_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= IW'(NUM_SW_INST - 1);
            fifo_rd_en  <= '0;
            sel_en      <= '0;
            wr_rd_s     <= 1'b0;
            addr        <= '0;
            wr_data     <= '0;
            op_id       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            last_grant  <= last_nxt;
            fifo_rd_en  <= rd_en_nxt;
            sel_en      <= sel_nxt;
            timeout_err <= expire;
            if (load) begin
                wr_data <= W_WIDTH'(frame_sel[7:0]);
                addr    <= W_WIDTH'(frame_sel[15:8]);
                op_id   <= frame_sel[23:16];
                wr_rd_s <= frame_sel[24];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last_grant;
        case (state)
            IDLE: begin
                state_nxt = rr_hit ? POP : IDLE;
                grant_nxt = rr_hit ? rr_idx : grant;
            end
            POP:  state_nxt = LOAD;
            LOAD: state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                state_nxt = done ? IDLE : WAIT_ACK;
                last_nxt  = done ? grant : last_grant;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so each appears one cycle after its state:
    // pop strobe in the cycle after POP, frame fields after LOAD, select after the first WAIT_ACK cycle.
    always_comb begin
        rd_en_nxt = (state == POP) ? grant_oh : '0;
        sel_nxt   = (state == WAIT_ACK && !done) ? grant_oh : '0;
        load      = (state == LOAD);
        busy      = (state != IDLE);
    end
endmodule
